sakebi_crc32_checker: RTL and testbench
=======================================

// Module: sakebi_crc32_checker
// PURPOSE
//  Receive-side Ethernet FCS checker. Consumes a byte stream that runs from
//  the first byte after the SFD through the 4 FCS bytes, and runs CRC-32 over
//  all of it. At end of frame it reports good/bad CRC, frame length and
//  length errors. Sits after the RX PHY deserializer, ahead of the frame parser.
// PARAMETERS
//  MIN_LEN  64     minimum legal frame length in bytes, FCS included
//  MAX_LEN  1518   maximum legal frame length in bytes, FCS included
//  LEN_W    11     width of the length counter; must hold MAX_LEN+1
// PORTS
//  i_clk      in   1      clock
//  i_rst_n    in   1      asynchronous active-low reset
//  i_valid    in   1      i_data holds a frame byte this cycle
//  i_data     in   8      frame byte
//  i_last     in   1      qualified by i_valid: this byte is the final FCS byte
//  i_abort    in   1      drop the current frame (PHY error / carrier loss)
//  o_done     out  1      1-cycle pulse: frame finished, status outputs valid
//  o_crc_ok   out  1      CRC residue matched; valid while o_done=1
//  o_len_err  out  1      length < MIN_LEN or > MAX_LEN; valid while o_done=1
//  o_len      out  LEN_W  bytes accepted, FCS included, saturating
//  o_valid    out  1      stripped payload byte valid (FCS_STRIP feature)
//  o_data     out  8      stripped payload byte
//  o_last     out  1      last payload byte of the frame
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, crc=32'hFFFFFFFF, len=0, delay line empty.
//  - CRC: reflected poly 32'hEDB88320, init all-ones, LSB-first per byte.
//    Frame is good iff the register equals 32'hDEBB20E3 after the last byte.
//    No final XOR is applied to the register.
//  - No backpressure. One byte per cycle maximum. Gaps (i_valid=0) are allowed
//    anywhere in a frame and do not change state.
//  - FSM IDLE->BODY on the first valid byte. BODY->IDLE on a valid byte with
//    i_last=1, or on i_abort. Each frame re-initialises crc to all-ones.
//  - The first byte may carry i_last=1 (1-byte frame). The check is then
//    evaluated on that byte and o_len_err=1.
//  - Latency: o_done/o_crc_ok/o_len_err/o_len are registered and appear
//    1 cycle after the i_last beat. They hold until the next o_done.
//  - len increments per accepted byte and saturates at 2^LEN_W-1. Saturation
//    implies o_len_err=1.
//  - i_abort has priority over a same-cycle valid byte. It causes no o_done
//    pulse, returns the FSM to IDLE and clears the delay line.
//  - i_abort in IDLE: no effect.
//  - Reset mid-frame: the frame is silently discarded, with no o_done.
// CONFIGURATION
//  SAKEBI_CRC32_CHK_FCS_STRIP_EN defined:
//   - A 4-byte delay line is instantiated. On accepted beat j (0-based,
//     j>=4), byte j-4 is emitted 1 cycle later on o_valid/o_data.
//   - o_last=i_last of beat j. The 4 FCS bytes are never emitted.
//   - Frames of <=4 bytes emit nothing.
//  Not defined: no delay line is built; o_valid/o_data/o_last are tied to 0.
// STRUCTURE
//  - Package sakebi_crc32_pkg: CRC32_POLY_REFL, CRC32_INIT, CRC32_RESIDUE,
//    FSM state typedef (IDLE, BODY).
//  - Sub-module sakebi_crc32_byte_step: combinational 8-bit reflected update
//    (crc_in, byte -> crc_out). It is shared with the TX FCS path.
// TESTING
//  - Reset: hold i_rst_n=0 -> all outputs 0.
//    Then a 64-byte frame with a correct FCS -> o_done=1, o_crc_ok=1,
//    o_len_err=0, o_len=64.
//  - "123456789" followed by 26 39 F4 CB -> o_crc_ok=1, o_len=13,
//    o_len_err=1 (runt).
//    Flip one data bit -> o_crc_ok=0.
//  - 64-byte good frame with 3 idle cycles inserted mid-frame ->
//    identical result, o_done exactly 1 cycle after the last byte.
//  - i_abort at byte 20 of a frame -> no o_done.
//    A following good frame with no gap -> o_crc_ok=1, o_len=64.
//  - 1519-byte frame -> o_len_err=1.
//    1-byte frame (i_last on the first beat) -> o_done=1, o_len=1, o_len_err=1.
//  - With STRIP_EN: a 64-byte frame yields exactly 60 o_valid beats equal to
//    bytes 0..59, with o_last on beat 59 in the same cycle as o_done.
//    Without STRIP_EN: o_valid stays 0.

Source files
------------

// File: rtl/sakebi_crc32_pkg.sv
// Shared constants and FSM state type for the CRC-32 FCS checker.
package sakebi_crc32_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic {
    IDLE,
    BODY
  } state_e;

endpackage

// File: rtl/sakebi_crc32_byte_step.sv
// Combinational one-byte update of a reflected CRC-32 register, LSB first.
module sakebi_crc32_byte_step
  import sakebi_crc32_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'h000000, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ({1'b0, c[31:1]} ^ CRC32_POLY_REFL) : {1'b0, c[31:1]};
    end
    crc_o = c;
  end

endmodule

// File: rtl/sakebi_crc32_checker.sv
// Receive-side Ethernet FCS checker: CRC-32 residue, length and length-error report.
// Define SAKEBI_CRC32_CHK_FCS_STRIP_EN to build the 4-byte delay line that strips the FCS.
module sakebi_crc32_checker
  import sakebi_crc32_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned LEN_W   = 11
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [7:0]       i_data,
  input  logic             i_last,
  input  logic             i_abort,
  output logic             o_done,
  output logic             o_crc_ok,
  output logic             o_len_err,
  output logic [LEN_W-1:0] o_len,
  output logic             o_valid,
  output logic [7:0]       o_data,
  output logic             o_last
);

  state_e           state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             done_q, done_d;
  logic             crc_ok_q, crc_ok_d;
  logic             len_err_q, len_err_d;
  logic [LEN_W-1:0] len_out_q, len_out_d;

  logic             first;
  logic [31:0]      crc_base, crc_step;
  logic [LEN_W-1:0] len_base, len_inc;
  logic             len_bad;

  // A new frame starts from fresh registers regardless of leftover state.
  assign first    = (state_q == IDLE);
  assign crc_base = first ? CRC32_INIT : crc_q;
  assign len_base = first ? '0 : len_q;
  assign len_inc  = (&len_base) ? len_base : len_base + LEN_W'(1);
  assign len_bad  = (&len_inc) | (len_inc < LEN_W'(MIN_LEN)) | (len_inc > LEN_W'(MAX_LEN));

  sakebi_crc32_byte_step u_step (
    .crc_i  (crc_base),
    .data_i (i_data),
    .crc_o  (crc_step)
  );

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    done_d    = 1'b0;
    crc_ok_d  = crc_ok_q;
    len_err_d = len_err_q;
    len_out_d = len_out_q;
    if (i_abort) begin
      state_d = IDLE;
      crc_d   = CRC32_INIT;
      len_d   = '0;
    end else if (i_valid) begin
      if (i_last) begin
        state_d   = IDLE;
        crc_d     = CRC32_INIT;
        len_d     = '0;
        done_d    = 1'b1;
        crc_ok_d  = (crc_step == CRC32_RESIDUE);
        len_err_d = len_bad;
        len_out_d = len_inc;
      end else begin
        state_d = BODY;
        crc_d   = crc_step;
        len_d   = len_inc;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      crc_q     <= CRC32_INIT;
      len_q     <= '0;
      done_q    <= 1'b0;
      crc_ok_q  <= 1'b0;
      len_err_q <= 1'b0;
      len_out_q <= '0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      done_q    <= done_d;
      crc_ok_q  <= crc_ok_d;
      len_err_q <= len_err_d;
      len_out_q <= len_out_d;
    end
  end

  assign o_done    = done_q;
  assign o_crc_ok  = crc_ok_q;
  assign o_len_err = len_err_q;
  assign o_len     = len_out_q;

`ifdef SAKEBI_CRC32_CHK_FCS_STRIP_EN
  // dl_q[0] is the newest byte, dl_q[3] the oldest; cnt_q counts filled slots.
  logic [3:0][7:0] dl_q, dl_d;
  logic [2:0]      cnt_q, cnt_d, cnt_base;
  logic            ov_q, ov_d;
  logic [7:0]      od_q, od_d;
  logic            ol_q, ol_d;

  assign cnt_base = first ? 3'd0 : cnt_q;

  always_comb begin
    dl_d  = dl_q;
    cnt_d = cnt_q;
    ov_d  = 1'b0;
    od_d  = od_q;
    ol_d  = 1'b0;
    if (i_abort) begin
      cnt_d = 3'd0;
    end else if (i_valid) begin
      dl_d  = {dl_q[2:0], i_data};
      cnt_d = (cnt_base == 3'd4) ? 3'd4 : cnt_base + 3'd1;
      if (cnt_base == 3'd4) begin
        ov_d = 1'b1;
        od_d = dl_q[3];
        ol_d = i_last;
      end
      if (i_last) begin
        cnt_d = 3'd0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dl_q  <= '0;
      cnt_q <= 3'd0;
      ov_q  <= 1'b0;
      od_q  <= 8'h00;
      ol_q  <= 1'b0;
    end else begin
      dl_q  <= dl_d;
      cnt_q <= cnt_d;
      ov_q  <= ov_d;
      od_q  <= od_d;
      ol_q  <= ol_d;
    end
  end

  assign o_valid = ov_q;
  assign o_data  = od_q;
  assign o_last  = ol_q;
`else
  assign o_valid = 1'b0;
  assign o_data  = 8'h00;
  assign o_last  = 1'b0;
`endif

endmodule

// File: tb/tb_sakebi_crc32_checker.sv
// Scoreboard bench for sakebi_crc32_checker; honours SAKEBI_CRC32_CHK_FCS_STRIP_EN.
module tb_sakebi_crc32_checker;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        i_last = 1'b0;
  logic        i_abort = 1'b0;
  logic        o_done, o_crc_ok, o_len_err, o_valid, o_last;
  logic [10:0] o_len;
  logic [7:0]  o_data;

  sakebi_crc32_checker #(
    .MIN_LEN (64),
    .MAX_LEN (1518),
    .LEN_W   (11)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .i_last    (i_last),
    .i_abort   (i_abort),
    .o_done    (o_done),
    .o_crc_ok  (o_crc_ok),
    .o_len_err (o_len_err),
    .o_len     (o_len),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_last    (o_last)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        crc_ok;
    logic        len_err;
    logic [10:0] len;
    int          due;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] pay_q[$];
  logic [7:0] frame_q[$];
  exp_t       mon_e;
  logic [8:0] mon_p;
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Bit-serial reference: one message bit at a time into a right-shifting register.
  function automatic logic [31:0] ref_crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: o_done=1 (len=%0d) required no pulse", o_len);
        end else begin
          mon_e = exp_q.pop_front();
          checks += 4;
          if (o_crc_ok !== mon_e.crc_ok) begin
            errors++;
            $display("FAIL crc_ok: got %b required %b", o_crc_ok, mon_e.crc_ok);
          end
          if (o_len_err !== mon_e.len_err) begin
            errors++;
            $display("FAIL len_err: got %b required %b", o_len_err, mon_e.len_err);
          end
          if (o_len !== mon_e.len) begin
            errors++;
            $display("FAIL len: got %0d required %0d", o_len, mon_e.len);
          end
          if (cyc != mon_e.due) begin
            errors++;
            $display("FAIL done_latency: got cycle %0d required %0d", cyc, mon_e.due);
          end
        end
`ifndef SAKEBI_CRC32_CHK_FCS_STRIP_EN
        checks++;
        if (o_valid !== 1'b0) begin
          errors++;
          $display("FAIL o_valid_tied: got %b required 0", o_valid);
        end
`endif
      end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        checks++;
        errors++;
        $display("FAIL done_missing: no o_done by cycle %0d required at %0d", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
`ifdef SAKEBI_CRC32_CHK_FCS_STRIP_EN
      if (o_valid) begin
        checks++;
        if (pay_q.size() == 0) begin
          errors++;
          $display("FAIL strip_extra: o_valid=1 data=%02h required no beat", o_data);
        end else begin
          mon_p = pay_q.pop_front();
          if ({o_last, o_data} !== mon_p) begin
            errors++;
            $display("FAIL strip_beat: got last=%b data=%02h required last=%b data=%02h",
                     o_last, o_data, mon_p[8], mon_p[7:0]);
          end
        end
        if (o_last) begin
          checks++;
          if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL strip_last_align: o_last=1 with o_done=%b required 1", o_done);
          end
        end
      end
`endif
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic last, input logic abrt);
    @(posedge i_clk);
    #1;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = last;
    i_abort = abrt;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      i_last  = 1'b0;
      i_abort = 1'b0;
    end
  endtask

  task automatic build_good(input int n);
    logic [31:0] c;
    frame_q.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n - 4; i++) begin
      frame_q.push_back(8'($urandom_range(0, 255)));
      c = ref_crc_byte(c, frame_q[i]);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) frame_q.push_back(c[8*i +: 8]);
  endtask

  task automatic send_frame(input int gap_at, input int gap_len, input int abort_at,
                            input logic exp_ok);
    int   n;
    exp_t e;
    logic last;
    n = frame_q.size();
    for (int j = 0; j < n; j++) begin
      if (j == gap_at) idle_cycles(gap_len);
      if (j == abort_at) begin
        send_byte(frame_q[j], 1'b0, 1'b1);
        return;
      end
      last = (j == n - 1);
      send_byte(frame_q[j], last, 1'b0);
`ifdef SAKEBI_CRC32_CHK_FCS_STRIP_EN
      if (j >= 4) pay_q.push_back({last, frame_q[j-4]});
`endif
      if (last) begin
        e.crc_ok  = exp_ok;
        e.len     = (n > 2047) ? 11'd2047 : 11'(n);
        e.len_err = (n < 64) || (n > 1518);
        e.due     = cyc + 1;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_drained(input string name);
    idle_cycles(4);
    checks++;
    if (exp_q.size() != 0 || pay_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: pending done=%0d beats=%0d required 0 and 0",
               name, exp_q.size(), pay_q.size());
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if ({o_done, o_crc_ok, o_len_err, o_len, o_valid, o_data, o_last} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs: got done=%b ok=%b lerr=%b len=%0d v=%b d=%02h l=%b required all 0",
               o_done, o_crc_ok, o_len_err, o_len, o_valid, o_data, o_last);
    end
    i_rst_n = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_good_frame();
    build_good(64);
    send_frame(-1, 0, -1, 1'b1);
    check_drained("good64");
  endtask

  task automatic test_check_vector();
    logic [7:0] v [13];
    v = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
          8'h26, 8'h39, 8'hF4, 8'hCB};
    frame_q.delete();
    for (int i = 0; i < 13; i++) frame_q.push_back(v[i]);
    send_frame(-1, 0, -1, 1'b1);
    idle_cycles(1);
    frame_q[4] = frame_q[4] ^ 8'h08;
    send_frame(-1, 0, -1, 1'b0);
    check_drained("check_vector");
  endtask

  task automatic test_gaps();
    build_good(64);
    send_frame(30, 3, -1, 1'b1);
    check_drained("gaps");
  endtask

  task automatic test_abort();
    build_good(64);
    send_frame(-1, 0, 20, 1'b1);
    build_good(64);
    send_frame(-1, 0, -1, 1'b1);
    check_drained("abort");
  endtask

  task automatic test_back_to_back();
    build_good(64);
    send_frame(-1, 0, -1, 1'b1);
    build_good(70);
    frame_q[10] = frame_q[10] ^ 8'h80;
    send_frame(-1, 0, -1, 1'b0);
    build_good(65);
    send_frame(-1, 0, -1, 1'b1);
    check_drained("back_to_back");
  endtask

  task automatic test_length_bounds();
    logic [31:0] c;
    build_good(1519);
    send_frame(-1, 0, -1, 1'b1);
    idle_cycles(1);
    build_good(1518);
    send_frame(-1, 0, -1, 1'b1);
    idle_cycles(1);
    frame_q.delete();
    frame_q.push_back(8'hA5);
    c = ref_crc_byte(32'hFFFFFFFF, 8'hA5);
    send_frame(-1, 0, -1, c == 32'hDEBB20E3);
    check_drained("length_bounds");
  endtask

  task automatic test_reset_mid_frame();
    build_good(64);
    for (int j = 0; j < 10; j++) send_byte(frame_q[j], 1'b0, 1'b0);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    pay_q.delete();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    check_drained("reset_mid");
    build_good(64);
    send_frame(-1, 0, -1, 1'b1);
    check_drained("after_reset");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_good_frame();
    test_check_vector();
    test_gaps();
    test_abort();
    test_back_to_back();
    test_length_bounds();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
